// File: rtl/seq_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_if
//   Bundle of the parallel-word handshake and the serial output stream of
//   seq_bit_serializer.
//
//   Signals
//     din        WIDTH  parallel word offered by the feeder
//     din_valid  1      din holds a word
//     din_ready  1      serializer can take a word this cycle
//     ser_out    1      serial bit stream (drives the detector's in_d)
//     ser_valid  1      ser_out carries a data bit this cycle
//     word_start 1      ser_out carries the first bit of a word
//     busy       1      shifting, or holding register occupied
//
//   Modports
//     master : the word feeder (drives din/din_valid, observes everything else)
//     slave  : the serializer itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             word_start;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  ser_out,
    input  ser_valid,
    input  word_start,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output ser_out,
    output ser_valid,
    output word_start,
    output busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
//   Upstream feeder for the serial sequence detector. Parallel words arrive on
//   a valid/ready handshake and are shifted out one bit per clock on ser_out.
//   A one-word holding register lets consecutive words stream with no idle bit
//   between them, so patterns spanning a word boundary remain visible to the
//   detector.
//
//   Parameters
//     WIDTH     bits per parallel word (>= 2)
//     MSB_FIRST 1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//     IDLE_BIT  level on ser_out while no word is being shifted
//
//   Ports
//     clk  in   single clock, all state on the rising edge
//     rst  in   asynchronous, active-low reset
//     bus  slave side of seq_bit_serializer_if (handshake + serial stream)
//
//   Every output is a flop; next-state and next-output values are computed
//   together in one combinational block and captured in one sequential block,
//   so there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_bit_serializer_if.slave  bus
);

  // Bit counter: just wide enough to index a word, compared against the last
  // bit position so it never wraps on its own.
  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [WIDTH-1:0] shreg_q,      shreg_d;
  logic [CW-1:0]    cnt_q,        cnt_d;
  logic [WIDTH-1:0] hold_q,       hold_d;
  logic             hold_full_q,  hold_full_d;

  logic             ser_out_q,    ser_out_d;
  logic             ser_valid_q,  ser_valid_d;
  logic             word_start_q, word_start_d;
  logic             busy_q,       busy_d;
  logic             din_ready_q,  din_ready_d;

  // ---------------------------------------------------------------------------
  // Word normalisation
  //   Both the shift register and the holding register store the word in
  //   transmission order, so the shifter always moves left and always emits
  //   bit WIDTH-1. For LSB-first operation the word is mirrored once on entry.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] din_norm;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign din_norm = bus.din;
    end else begin : g_lsb_first
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mirror
        assign din_norm[gi] = bus.din[WIDTH-1-gi];
      end
    end
  endgenerate

  // A word moves across the interface only on an edge with valid && ready.
  logic xfer;
  assign xfer = bus.din_valid && din_ready_q;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    case (state_q)
      S_IDLE: begin
        // Nothing in flight and the holding register is always empty here,
        // so an accepted word goes straight into the shifter.
        if (xfer) begin
          shreg_d = din_norm;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          // Last bit of the current word is on ser_out this cycle; decide
          // what follows it without leaving a gap when another word exists.
          cnt_d = '0;
          if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            // Bypass: a word accepted exactly on the last-bit edge follows
            // immediately instead of passing through the holding register.
            shreg_d = din_norm;
          end else begin
            shreg_d = '0;
            state_d = S_IDLE;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
          // din_ready is low whenever the holding register is full, so this
          // can never overwrite a waiting word.
          if (xfer) begin
            hold_d      = din_norm;
            hold_full_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs describe the cycle that follows the edge, so they are derived
    // from the next-state values and then registered.
    ser_valid_d  = (state_d == S_SHIFT);
    word_start_d = (state_d == S_SHIFT) && (cnt_d == '0);
    ser_out_d    = (state_d == S_SHIFT) ? shreg_d[WIDTH-1] : IDLE_BIT;
    busy_d       = (state_d == S_SHIFT) || hold_full_d;
    din_ready_d  = !hold_full_d;
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset discards any partial word and any held word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      ser_out_q    <= IDLE_BIT;
      ser_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
      busy_q       <= 1'b0;
      din_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      word_start_q <= word_start_d;
      busy_q       <= busy_d;
      din_ready_q  <= din_ready_d;
    end
  end

  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.word_start = word_start_q;
  assign bus.busy       = busy_q;
  assign bus.din_ready  = din_ready_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
`timescale 1ns/1ps

module tb_seq_bit_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) bus_m ();
  seq_bit_serializer_if #(.WIDTH(W)) bus_l ();

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_l)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture state for the MSB-first instance plus a tiny overlapping 1011
  // detector standing in for the downstream seq_dect.
  logic [31:0] cap_bits;
  logic [3:0]  win;
  int          cap_n, cap_starts, cap_gaps, cap_nrdy, det_cnt, det_first_end;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_bits      = '0;
    win           = '0;
    cap_n         = 0;
    cap_starts    = 0;
    cap_gaps      = 0;
    cap_nrdy      = 0;
    det_cnt       = 0;
    det_first_end = -1;
  endtask

  // Record the current cycle of dut_msb, then advance one clock.
  task automatic sample_bit();
    cap_bits = {cap_bits[30:0], bus_m.ser_out};
    if (!bus_m.ser_valid)  cap_gaps++;
    if (bus_m.word_start)  cap_starts++;
    if (!bus_m.din_ready)  cap_nrdy++;
    if (bus_m.ser_valid) begin
      win = {win[2:0], bus_m.ser_out};
      if (win == 4'b1011) begin
        det_cnt++;
        if (det_first_end < 0) det_first_end = cap_n;
      end
    end
    cap_n++;
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ser_valid"}, 32'(bus_m.ser_valid), 32'd0);
    check({tag, "_ser_out"},   32'(bus_m.ser_out),   32'd0);
    check({tag, "_busy"},      32'(bus_m.busy),      32'd0);
    check({tag, "_din_ready"}, 32'(bus_m.din_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] lsb_bits;
    int         lsb_starts;
    int         valid_seen;

    // ---------------- Test 1: reset with din_valid asserted ----------------
    rst_n           = 1'b0;
    bus_m.din       = 8'hAA;
    bus_m.din_valid = 1'b1;
    bus_l.din       = 8'h00;
    bus_l.din_valid = 1'b0;
    repeat (3) tick();
    check_idle("rst_hold");
    check("rst_hold_word_start", 32'(bus_m.word_start), 32'd0);
    bus_m.din_valid = 1'b0;
    rst_n           = 1'b1;
    repeat (3) tick();
    check_idle("rst_release");
    $display("T1 reset: ser_valid=%0b din_ready=%0b busy=%0b", bus_m.ser_valid, bus_m.din_ready, bus_m.busy);

    // ---------------- Test 2: single word 0xB0, MSB first ----------------
    clear_cap();
    bus_m.din       = 8'hB0;
    bus_m.din_valid = 1'b1;
    check("t2_no_comb_path", 32'(bus_m.ser_valid), 32'd0);
    tick();
    bus_m.din_valid = 1'b0;
    check("t2_latency_valid", 32'(bus_m.ser_valid), 32'd1);
    check("t2_first_start",   32'(bus_m.word_start), 32'd1);
    repeat (8) sample_bit();
    check("t2_bits",   cap_bits & 32'hFF, 32'h0000_00B0);
    check("t2_starts", 32'(cap_starts), 32'd1);
    check("t2_gaps",   32'(cap_gaps),   32'd0);
    check("t2_detect", 32'(det_cnt),    32'd1);
    check_idle("t2_after");
    $display("T2 word 0xB0 -> stream 0x%02h starts=%0d detections=%0d", cap_bits[7:0], cap_starts, det_cnt);

    // ---------------- Test 3: back-to-back 0x05 then 0xB0 ----------------
    clear_cap();
    bus_m.din       = 8'h05;
    bus_m.din_valid = 1'b1;
    tick();
    bus_m.din = 8'hB0;
    sample_bit();
    bus_m.din_valid = 1'b0;
    check("t3_ready_low", 32'(bus_m.din_ready), 32'd0);
    check("t3_busy",      32'(bus_m.busy),      32'd1);
    repeat (15) sample_bit();
    check("t3_bits",       cap_bits & 32'hFFFF, 32'h0000_05B0);
    check("t3_gaps",       32'(cap_gaps),   32'd0);
    check("t3_starts",     32'(cap_starts), 32'd2);
    check("t3_nrdy",       32'(cap_nrdy),   32'd7);
    check("t3_detect",     32'(det_cnt),    32'd2);
    check("t3_span_end",   32'(det_first_end), 32'd8);
    check_idle("t3_after");
    $display("T3 words 0x05,0xB0 -> stream 0x%04h ready_low=%0d detections=%0d", cap_bits[15:0], cap_nrdy, det_cnt);

    // ---------------- Test 4: bypass on the last-bit edge ----------------
    clear_cap();
    bus_m.din       = 8'hFF;
    bus_m.din_valid = 1'b1;
    tick();
    bus_m.din_valid = 1'b0;
    repeat (7) sample_bit();
    bus_m.din       = 8'h00;
    bus_m.din_valid = 1'b1;
    sample_bit();
    bus_m.din_valid = 1'b0;
    repeat (8) sample_bit();
    check("t4_bits",   cap_bits & 32'hFFFF, 32'h0000_FF00);
    check("t4_gaps",   32'(cap_gaps),   32'd0);
    check("t4_starts", 32'(cap_starts), 32'd2);
    check("t4_nrdy",   32'(cap_nrdy),   32'd0);
    check_idle("t4_after");
    $display("T4 words 0xFF,0x00 (bypass) -> stream 0x%04h gaps=%0d", cap_bits[15:0], cap_gaps);

    // ---------------- Test 5: LSB first, 0x0D ----------------
    lsb_bits        = '0;
    lsb_starts      = 0;
    bus_l.din       = 8'h0D;
    bus_l.din_valid = 1'b1;
    tick();
    bus_l.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5_valid", 32'(bus_l.ser_valid), 32'd1);
      lsb_bits = {lsb_bits[6:0], bus_l.ser_out};
      if (bus_l.word_start) lsb_starts++;
      tick();
    end
    check("t5_bits",   32'(lsb_bits),   32'h0000_00B0);
    check("t5_starts", 32'(lsb_starts), 32'd1);
    check("t5_after_valid", 32'(bus_l.ser_valid), 32'd0);
    $display("T5 LSB-first word 0x0D -> stream 0x%02h", lsb_bits);

    // ---------------- Test 6: reset mid-word with hold full ----------------
    bus_m.din       = 8'hA5;
    bus_m.din_valid = 1'b1;
    tick();
    bus_m.din = 8'h3C;
    tick();
    bus_m.din_valid = 1'b0;
    check("t6_hold_full", 32'(bus_m.din_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_idle("t6_async");
    check("t6_async_word_start", 32'(bus_m.word_start), 32'd0);
    tick();
    rst_n = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_m.ser_valid || bus_m.busy) valid_seen++;
      tick();
    end
    check("t6_words_lost", 32'(valid_seen), 32'd0);
    clear_cap();
    bus_m.din       = 8'h81;
    bus_m.din_valid = 1'b1;
    tick();
    bus_m.din_valid = 1'b0;
    repeat (8) sample_bit();
    check("t6_new_bits",   cap_bits & 32'hFF, 32'h0000_0081);
    check("t6_new_starts", 32'(cap_starts), 32'd1);
    check("t6_new_gaps",   32'(cap_gaps),   32'd0);
    check_idle("t6_after");
    $display("T6 reset mid-word: idle cycles with activity=%0d, new word 0x81 -> stream 0x%02h", valid_seen, cap_bits[7:0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
